// File: rtl/avalon_trig_bank.sv
`default_nettype none
// ============================================================================
// Module      : avalon_trig_bank
// Description : Avalon-MM bank of NUM_CH trigger-level registers. Software
//               writes shadow copies; the active levels driving the trigger
//               comparators are reloaded all at once on an acquisition frame
//               sync, a forced commit, or a pending-commit timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_trig_bank #(
    parameter int DATA_W    = 8,
    parameter int NUM_CH    = 4,
    parameter int ADDR_W    = 3,
    parameter int RESET_VAL = 127,
    parameter int TIMEOUT   = 1000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        address,
    input  logic                     chipselect,
    input  logic                     read,
    input  logic                     write_n,
    input  logic [31:0]              writedata,
    output logic [31:0]              readdata,
    input  logic                     frame_sync,
    output logic [NUM_CH*DATA_W-1:0] out_port,
    output logic                     commit_done
);

    // TIMEOUT = 0 still needs a one-bit counter so the design elaborates.
    localparam int c_TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [ADDR_W-1:0]  c_ADDR_CTRL   = ADDR_W'(NUM_CH);
    localparam logic [ADDR_W-1:0]  c_ADDR_STATUS = ADDR_W'(NUM_CH + 1);
    localparam logic [DATA_W-1:0]  c_RESET_LVL   = DATA_W'(RESET_VAL);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST    = c_TMR_W'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_shadow [NUM_CH];
    logic [DATA_W-1:0]   r_active [NUM_CH];
    logic                r_auto;
    logic                r_to_flag;
    logic [7:0]          r_count;
    logic [c_TMR_W-1:0]  r_timer;
    logic [c_TMR_W-1:0]  w_timer_nxt;
    logic [31:0]         r_readdata;
    logic                r_commit_done;

    logic        w_wr;
    logic        w_rd;
    logic        w_shadow_wr;
    logic        w_ctrl_wr;
    logic        w_status_wr;
    logic        w_force;
    logic        w_req;
    logic        w_pending;
    logic        w_to_hit;
    logic        w_copy;
    logic        w_to_set;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_wr        = chipselect & ~write_n;
    assign w_rd        = chipselect & read;
    assign w_shadow_wr = w_wr & (address < c_ADDR_CTRL);
    assign w_ctrl_wr   = w_wr & (address == c_ADDR_CTRL);
    assign w_status_wr = w_wr & (address == c_ADDR_STATUS);
    assign w_force     = w_ctrl_wr & writedata[1];
    // AUTO here is the value held before this cycle's write.
    assign w_req       = (w_ctrl_wr & writedata[0]) | (w_shadow_wr & r_auto);
    assign w_pending   = (r_state == ST_PENDING);
    assign w_to_hit    = (TIMEOUT != 0) && (r_timer == c_TMR_LAST);
    // FORCE wins over frame_sync and timeout, and never flags a timeout.
    assign w_copy      = w_force | (w_pending & (frame_sync | w_to_hit));
    assign w_to_set    = w_pending & ~w_force & ~frame_sync & w_to_hit;
    assign w_unused    = ^writedata[31:DATA_W];

    assign readdata    = r_readdata;
    assign commit_done = r_commit_done;

    // Per-channel shadow and active level registers.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        always_ff @(posedge clk) begin
            if (reset) begin
                r_shadow[g] <= c_RESET_LVL;
                r_active[g] <= c_RESET_LVL;
            end else begin
                if (w_copy)
                    r_active[g] <= r_shadow[g];
                if (w_shadow_wr && (address == ADDR_W'(g)))
                    r_shadow[g] <= writedata[DATA_W-1:0];
            end
        end
        assign out_port[g*DATA_W +: DATA_W] = r_active[g];
    end

    // Read-data mux from the current register contents.
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (address == ADDR_W'(i))
                w_rdata = 32'(r_shadow[i]);
        if (address == c_ADDR_CTRL)
            w_rdata = {29'b0, r_auto, 2'b00};
        if (address == c_ADDR_STATUS)
            w_rdata = {16'b0, r_count, 6'b0, r_to_flag, w_pending};
    end

    // Next state and timeout counter; a copy that coincides with an AUTO
    // shadow write re-arms immediately with a fresh timer.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        if (w_copy) begin
            w_state_nxt = (w_shadow_wr && r_auto) ? ST_PENDING : ST_IDLE;
            w_timer_nxt = '0;
        end else if (r_state == ST_IDLE) begin
            if (w_req) begin
                w_state_nxt = ST_PENDING;
                w_timer_nxt = '0;
            end
        end else begin
            w_timer_nxt = r_timer + 1'b1;
        end
    end

    // State, control/status and bus-side registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_timer       <= '0;
            r_auto        <= 1'b0;
            r_to_flag     <= 1'b0;
            r_count       <= 8'd0;
            r_readdata    <= 32'd0;
            r_commit_done <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_commit_done <= w_copy;
            if (w_ctrl_wr)
                r_auto <= writedata[2];
            if (w_to_set)
                r_to_flag <= 1'b1;
            else if (w_status_wr && writedata[1])
                r_to_flag <= 1'b0;
            if (w_copy)
                r_count <= r_count + 8'd1;
            if (w_rd)
                r_readdata <= w_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_avalon_trig_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_trig_bank
// Description : Self-checking bench for avalon_trig_bank with a behavioural
//               register-bank model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_trig_bank;

    localparam int NUM_CH  = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        read;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        frame_sync;
    logic [31:0] out_port;
    logic        commit_done;

    int n_checks = 0;
    int n_errs   = 0;

    avalon_trig_bank #(
        .DATA_W(8), .NUM_CH(NUM_CH), .ADDR_W(3), .RESET_VAL(127), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read(read), .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .frame_sync(frame_sync), .out_port(out_port), .commit_done(commit_done)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    logic [7:0]  m_sh [NUM_CH];
    logic [7:0]  m_ac [NUM_CH];
    bit          m_auto, m_pend, m_to, m_done, m_valid = 0;
    int          m_cnt;
    longint      ncyc = 0, pend_since = 0;
    logic [31:0] m_rd;

    // Model one bus/frame clock edge from the inputs held during the cycle.
    always @(posedge clk) begin : model
        bit wr, rd, shw, ctw, stw, frc, req, tmo, copy;
        ncyc++;
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin m_sh[i] = 8'h7F; m_ac[i] = 8'h7F; end
            m_auto = 0; m_pend = 0; m_to = 0; m_done = 0; m_cnt = 0; m_rd = 0;
            m_valid = 1;
        end else if (m_valid) begin
            wr   = chipselect && !write_n;
            rd   = chipselect && read;
            shw  = wr && (address < NUM_CH);
            ctw  = wr && (address == NUM_CH);
            stw  = wr && (address == NUM_CH + 1);
            frc  = ctw && writedata[1];
            req  = (ctw && writedata[0]) || (shw && m_auto);
            tmo  = m_pend && (TIMEOUT != 0) && (ncyc - pend_since == TIMEOUT);
            copy = frc || (m_pend && (frame_sync || tmo));
            if (rd) begin
                if (address < NUM_CH)          m_rd = {24'b0, m_sh[address]};
                else if (address == NUM_CH)    m_rd = {29'b0, m_auto, 2'b0};
                else if (address == NUM_CH + 1) m_rd = (m_cnt << 8) | (m_to << 1) | m_pend;
                else                           m_rd = 0;
            end
            m_done = copy;
            if (copy) begin
                for (int i = 0; i < NUM_CH; i++) m_ac[i] = m_sh[i];
                m_cnt = (m_cnt + 1) % 256;
            end
            if (stw && writedata[1]) m_to = 0;
            if (copy && tmo && !frc && !frame_sync) m_to = 1;
            if (copy) begin
                m_pend = shw && m_auto;
                pend_since = ncyc;
            end else if (!m_pend && req) begin
                m_pend = 1;
                pend_since = ncyc;
            end
            if (shw) m_sh[address] = writedata[7:0];
            if (ctw) m_auto = writedata[2];
        end
    end

    // Compare every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (m_valid) begin
            check("out_port", out_port, {m_ac[3], m_ac[2], m_ac[1], m_ac[0]});
            check("commit_done", {31'b0, commit_done}, {31'b0, m_done});
            check("readdata", readdata, m_rd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(bit cs, bit rd, bit wn, int a, logic [31:0] d, bit fs, bit rst);
        @(posedge clk);
        #2;
        chipselect = cs; read = rd; write_n = wn; address = a[2:0];
        writedata = d; frame_sync = fs; reset = rst;
    endtask

    task automatic idle(int n);
        repeat (n) drive(0, 0, 1, 0, 32'h0, 0, 0);
    endtask

    task automatic wr(int a, logic [31:0] d);
        drive(1, 0, 0, a, d, 0, 0);
    endtask

    task automatic rdreg(int a, output logic [31:0] v);
        drive(1, 1, 1, a, 32'h0, 0, 0);
        drive(0, 0, 1, 0, 32'h0, 0, 0);
        v = readdata;
    endtask

    initial begin
        logic [31:0] v;
        int k, pulses;
        chipselect = 0; read = 0; write_n = 1; address = 0;
        writedata = 0; frame_sync = 0; reset = 1;
        repeat (3) drive(0, 0, 1, 0, 32'h0, 0, 1);
        idle(1);

        // Reset state
        for (int i = 0; i < NUM_CH; i++) begin
            rdreg(i, v);
            check("rst_shadow", v, 32'h7F);
        end
        check("rst_out", out_port, 32'h7F7F7F7F);
        rdreg(5, v); check("rst_status", v, 32'h0);
        rdreg(4, v); check("rst_ctrl", v, 32'h0);

        // Commit on frame sync
        wr(2, 32'h40); wr(4, 32'h1); idle(5);
        check("pend_hold", out_port, 32'h7F7F7F7F);
        rdreg(5, v); check("pend_bit", v, 32'h1);
        drive(0, 0, 1, 0, 32'h0, 1, 0);
        idle(1);
        check("fs_done", {31'b0, commit_done}, 32'h1);
        check("fs_load", out_port, 32'h7F407F7F);
        rdreg(5, v); check("fs_status", v, 32'h0100);

        // Timeout commit latency and TO_FLAG
        wr(4, 32'h1);
        k = 0;
        for (int i = 1; i <= 40 && k == 0; i++) begin
            idle(1);
            if (commit_done) k = i;
        end
        check("timeout_lat", k, 17);
        rdreg(5, v); check("to_status", v, 32'h0202);
        wr(5, 32'h2);
        rdreg(5, v); check("to_clear", v, 32'h0200);

        // AUTO with shadow write on the copy edge
        wr(4, 32'h4);
        wr(1, 32'h22);
        drive(1, 0, 0, 0, 32'h10, 1, 0);
        idle(1);
        check("auto_done", {31'b0, commit_done}, 32'h1);
        check("auto_old", out_port, 32'h7F40227F);
        rdreg(5, v); check("auto_rearm", v, 32'h0301);
        drive(0, 0, 1, 0, 32'h0, 1, 0);
        idle(1);
        check("auto_load", out_port, 32'h7F402210);
        rdreg(5, v); check("auto_status", v, 32'h0400);

        // FORCE and frame sync together
        wr(4, 32'h1); idle(2);
        drive(1, 0, 0, 4, 32'h2, 1, 0);
        pulses = 0;
        repeat (6) begin idle(1); if (commit_done) pulses++; end
        check("force_fs_pulses", pulses, 1);
        rdreg(5, v); check("force_status", v, 32'h0500);

        // Reset mid-PENDING
        wr(0, 32'h55); wr(3, 32'h66); wr(4, 32'h1); idle(2);
        drive(0, 0, 1, 0, 32'h0, 0, 1);
        idle(1);
        check("rst_pend_out", out_port, 32'h7F7F7F7F);
        drive(0, 0, 1, 0, 32'h0, 1, 0);
        pulses = 0;
        repeat (4) begin idle(1); if (commit_done) pulses++; end
        check("rst_pend_nocommit", pulses, 0);
        rdreg(0, v); check("rst_pend_shadow", v, 32'h7F);

        // Commit counter wrap
        repeat (255) wr(4, 32'h2);
        idle(1);
        rdreg(5, v); check("count_255", v, 32'hFF00);
        wr(4, 32'h2); idle(1);
        rdreg(5, v); check("count_wrap", v, 32'h0);

        // Random traffic against the model
        repeat (4000) begin
            int a;
            logic [31:0] d;
            a = $urandom_range(0, 7);
            d = $urandom;
            if (a == 4 && $urandom_range(0, 3) != 0) d[1] = 1'b0;
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  a, d, $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
`default_nettype wire
